mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the CPU's single external memory bus between instruction fetch and the MEM stage's load/store port. Fetch is driven by the PC register's address and chip-enable. The block runs each access as a registered request/acknowledge bus cycle and raises per-requester stall requests to the pipeline controller until that requester's access has completed. Completed results are held until the pipeline advances or is flushed.

## Interface
Reset is rst, synchronous, active-high; the clock is clk.

Parameters:
- TIMEOUT, 16, cycles a bus access may wait for ack before abort (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_ce_i  in  1  fetch request (PC chip-enable)
- if_addr_i  in  32  fetch address (PC)
- if_inst_o  out  32  fetched instruction, held while if_done
- if_stall_req_o  out  1  fetch not yet satisfied
- if_err_o  out  1  fetch ended by timeout
- mem_ce_i  in  1  data access request
- mem_we_i  in  1  1 = store
- mem_addr_i  in  32  data address
- mem_data_i  in  32  store data
- mem_sel_i  in  4  byte enables
- mem_data_o  out  32  load data, held while mem_done
- mem_stall_req_o  out  1  data access not yet satisfied
- mem_err_o  out  1  data access ended by timeout
- pipe_adv_i  in  1  pipeline advanced this cycle (no stall)
- flush_i  in  1  pipeline flush (branch/exception)
- bus_cyc_o  out  1  bus cycle active
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  bus address
- bus_data_o  out  32  bus write data
- bus_sel_o  out  4  bus byte enables
- bus_data_i  in  32  bus read data
- bus_ack_i  in  1  bus acknowledge, valid only while bus_cyc_o

## Operation
- States are IDLE, IF_ACC and MEM_ACC. Reset gives state IDLE with every output 0 and both done flags and the discard flag cleared.
- Pending conditions:
  - mem_pend = mem_ce_i & ~mem_done.
  - if_pend = if_ce_i & ~if_done & (~mem_ce_i | mem_done).
  - MEM has strict priority; fetch starts only after any MEM-stage access is satisfied.
- IDLE:
  - If mem_pend and not flush_i, load the bus registers from the mem_* inputs, set bus_cyc_o and go to MEM_ACC.
  - Else if if_pend and not flush_i, load if_addr_i with we=0 and sel=4'hF, and go to IF_ACC.
- *_ACC:
  - Bus outputs are held stable.
  - On bus_ack_i: drop bus_cyc_o and go to IDLE. If discard is clear, capture bus_data_i into the requester's result register (stores capture nothing) and set its done flag. Clear discard.
- Stall requests are combinational: if_stall_req_o = if_ce_i & ~if_done, and mem_stall_req_o = mem_ce_i & ~mem_done.
- pipe_adv_i clears both done flags and both err flags; result registers keep their values.
- flush_i:
  - Clears both done flags and err flags.
  - If in an ACC state, sets discard. The bus cycle is never aborted, so stores complete, but the result is dropped.
  - No new access starts in the flush cycle.
- Simultaneous pipe_adv_i and ack: the done flag is set and the advance clear is not applied to the newly completed access.

## Timing
- Minimum access: request seen in cycle 0, bus_cyc_o high in cycle 1, ack in cycle 1, done and result valid in cycle 2 with the stall dropped in cycle 2.
- IDLE lasts at least one cycle between consecutive bus cycles.
- Load followed by fetch, zero wait states: mem_done in cycle 2, fetch bus cycle in cycle 3, if_done in cycle 4.
- rst has priority over every event mid-access: bus_cyc_o drops on the next edge and state returns to IDLE.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter runs in the ACC states.
  - When no ack arrives after TIMEOUT cycles with bus_cyc_o high, drop bus_cyc_o, go to IDLE, set the requester's done flag with result 0, and set its err flag (unless discard is set).
  - Err flags clear like the done flags.
- ARB_TIMEOUT_EN undefined: the block waits for ack indefinitely, there is no counter, and if_err_o and mem_err_o are constant 0.

## Test plan
- Reset: hold rst 2 cycles with requests active -> all outputs 0 and no bus_cyc_o until one cycle after rst drops.
- Fetch, zero wait states: if_addr_i=0x00000004 and bus returns 0x3C010001 on first ack -> if_inst_o=0x3C010001 in cycle 2, if_stall_req_o low in cycle 2, and it stays low until pipe_adv_i.
- Priority: mem_ce_i load at 0x100 and if_ce_i together, 2 wait states -> MEM bus cycle first, then fetch. Both stalls low only after both done, and one pipe_adv_i clears both.
- Store: mem_we_i=1, sel=4'b0011, data 0xDEADBEEF -> bus_we_o=1, bus_sel_o=0011 and bus_data_o=0xDEADBEEF held until ack; mem_data_o unchanged.
- Flush mid-fetch: flush_i during IF_ACC -> bus cycle completes, if_done stays 0, and a new fetch starts one cycle after IDLE with the new address.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=16): no ack -> bus_cyc_o drops after 16 cycles, if_err_o=1 and if_inst_o=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single external-bus arbiter: MEM load/store port has strict priority over instruction fetch.
// Define ARB_TIMEOUT_EN to abort bus cycles that get no ack within TIMEOUT cycles.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_inst_o,
  output logic        if_stall_req_o,
  output logic        if_err_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stall_req_o,
  output logic        mem_err_o,
  input  logic        pipe_adv_i,
  input  logic        flush_i,
  output logic        bus_cyc_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i
);
  localparam logic [1:0] S_IDLE = 2'd0, S_IF = 2'd1, S_MEM = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        cyc_q, cyc_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdat_q, wdat_d;
  logic [3:0]  sel_q, sel_d;
  logic        if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic        discard_q, discard_d;
  logic [31:0] inst_q, inst_d, rdata_q, rdata_d;
  logic        mem_pend, if_pend, in_acc, tmo, fin, drop;

  assign mem_pend = mem_ce_i & ~mem_done_q;
  assign if_pend  = if_ce_i & ~if_done_q & (~mem_ce_i | mem_done_q);
  assign in_acc   = (state_q != S_IDLE);
  assign fin      = in_acc & (bus_ack_i | tmo);
  // A flush arriving in the completion cycle still drops that result.
  assign drop     = discard_q | flush_i;

  always_comb begin
    state_d = state_q; cyc_d = cyc_q; we_d = we_q; addr_d = addr_q;
    wdat_d = wdat_q; sel_d = sel_q; discard_d = discard_q;
    if_done_d = if_done_q; mem_done_d = mem_done_q;
    inst_d = inst_q; rdata_d = rdata_q;
    if (pipe_adv_i | flush_i) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (!flush_i) begin
          if (mem_pend) begin
            state_d = S_MEM; cyc_d = 1'b1; we_d = mem_we_i;
            addr_d = mem_addr_i; wdat_d = mem_data_i; sel_d = mem_sel_i;
          end else if (if_pend) begin
            state_d = S_IF; cyc_d = 1'b1; we_d = 1'b0;
            addr_d = if_addr_i; wdat_d = 32'h0; sel_d = 4'hF;
          end
        end
      end
      default: begin
        if (flush_i) discard_d = 1'b1;
        if (fin) begin
          state_d = S_IDLE; cyc_d = 1'b0; discard_d = 1'b0;
          // Completion sets done after the advance clear above, so it survives pipe_adv_i.
          if (!drop) begin
            if (state_q == S_IF) begin
              if_done_d = 1'b1;
              inst_d    = tmo ? 32'h0 : bus_data_i;
            end else begin
              mem_done_d = 1'b1;
              if (!we_q || tmo) rdata_d = tmo ? 32'h0 : bus_data_i;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; cyc_q <= 1'b0; we_q <= 1'b0; addr_q <= 32'h0;
      wdat_q <= 32'h0; sel_q <= 4'h0; discard_q <= 1'b0;
      if_done_q <= 1'b0; mem_done_q <= 1'b0; inst_q <= 32'h0; rdata_q <= 32'h0;
    end else begin
      state_q <= state_d; cyc_q <= cyc_d; we_q <= we_d; addr_q <= addr_d;
      wdat_q <= wdat_d; sel_q <= sel_d; discard_q <= discard_d;
      if_done_q <= if_done_d; mem_done_q <= mem_done_d; inst_q <= inst_d; rdata_q <= rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       if_err_q, if_err_d, mem_err_q, mem_err_d;

  assign tmo   = in_acc & ~bus_ack_i & (cnt_q == 8'(TIMEOUT - 1));
  assign cnt_d = (in_acc && !fin) ? cnt_q + 8'd1 : 8'd0;

  always_comb begin
    if_err_d = if_err_q; mem_err_d = mem_err_q;
    if (pipe_adv_i | flush_i) begin
      if_err_d  = 1'b0;
      mem_err_d = 1'b0;
    end
    if (tmo && !drop) begin
      if (state_q == S_IF) if_err_d = 1'b1;
      else                 mem_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0; if_err_q <= 1'b0; mem_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d; if_err_q <= if_err_d; mem_err_q <= mem_err_d;
    end
  end

  assign if_err_o  = if_err_q;
  assign mem_err_o = mem_err_q;
`else
  assign tmo       = 1'b0;
  assign if_err_o  = 1'b0;
  assign mem_err_o = 1'b0;
`endif

  // Stalls are masked during reset so every output reads 0 while rst is held.
  assign if_stall_req_o  = ~rst & if_ce_i & ~if_done_q;
  assign mem_stall_req_o = ~rst & mem_ce_i & ~mem_done_q;
  assign if_inst_o  = inst_q;
  assign mem_data_o = rdata_q;
  assign bus_cyc_o  = cyc_q;
  assign bus_we_o   = we_q;
  assign bus_addr_o = addr_q;
  assign bus_data_o = wdat_q;
  assign bus_sel_o  = sel_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// against a transaction-level model (bench acts as bus slave with a synthetic memory).
module tb_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_ce_i = 1'b0, mem_ce_i = 1'b0, mem_we_i = 1'b0;
  logic [31:0] if_addr_i = '0, mem_addr_i = '0, mem_data_i = '0, bus_data_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic        pipe_adv_i = 1'b0, flush_i = 1'b0, bus_ack_i = 1'b0;
  logic [31:0] if_inst_o, mem_data_o, bus_addr_o, bus_data_o;
  logic        if_stall_req_o, if_err_o, mem_stall_req_o, mem_err_o, bus_cyc_o, bus_we_o;
  logic [3:0]  bus_sel_o;

  int checks = 0, failures = 0;
  logic [31:0] exp_inst = '0, exp_mdata = '0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o),
    .if_stall_req_o(if_stall_req_o), .if_err_o(if_err_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_sel_i(mem_sel_i), .mem_data_o(mem_data_o),
    .mem_stall_req_o(mem_stall_req_o), .mem_err_o(mem_err_o),
    .pipe_adv_i(pipe_adv_i), .flush_i(flush_i),
    .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o), .bus_sel_o(bus_sel_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] fmem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Wait for a bus cycle, check its fields every cycle, ack after 'waits' wait states.
  task automatic serve(input string tag, input logic [31:0] ea, input logic ewe,
                       input logic [3:0] esel, input logic [31:0] ed, input int waits,
                       input logic [31:0] rdat, input logic adv, output int lat);
    lat = 0;
    while (!bus_cyc_o && lat < 40) begin tick; lat++; end
    chk({tag, "_cyc"}, 32'(bus_cyc_o), 32'd1);
    for (int w = 0; w <= waits; w++) begin
      chk({tag, "_addr"}, bus_addr_o, ea);
      chk({tag, "_we"}, 32'(bus_we_o), 32'(ewe));
      chk({tag, "_sel"}, 32'(bus_sel_o), 32'(esel));
      if (ewe) chk({tag, "_wdat"}, bus_data_o, ed);
      if (w == waits) begin bus_ack_i = 1'b1; bus_data_i = rdat; pipe_adv_i = adv; end
      tick;
    end
    bus_ack_i = 1'b0; bus_data_i = '0; pipe_adv_i = 1'b0;
    chk({tag, "_cyc_drop"}, 32'(bus_cyc_o), 32'd0);
  endtask

  task automatic advance;
    pipe_adv_i = 1'b1; tick; pipe_adv_i = 1'b0;
  endtask

  initial begin
    int lat, n;
    // Reset with requests active
    if_ce_i = 1'b1; if_addr_i = 32'h20; mem_ce_i = 1'b1; mem_addr_i = 32'h10; mem_sel_i = 4'hF;
    tick; tick;
    chk("rst_outs", {if_inst_o[7:0] | mem_data_o[7:0] | bus_addr_o[7:0] | bus_data_o[7:0],
                     20'h0, bus_sel_o, if_stall_req_o, mem_stall_req_o, if_err_o, mem_err_o},
        32'h0);
    chk("rst_cyc", 32'(bus_cyc_o), 32'd0);
    rst = 1'b0; #1;
    chk("rst_drop_cyc", 32'(bus_cyc_o), 32'd0);
    tick;
    chk("post_rst_cyc", 32'(bus_cyc_o), 32'd1);
    chk("post_rst_addr", bus_addr_o, 32'h10);
    rst = 1'b1; tick;
    chk("rst_midacc_cyc", 32'(bus_cyc_o), 32'd0);
    if_ce_i = 1'b0; mem_ce_i = 1'b0; tick; rst = 1'b0; tick;
    chk("rst_idle", 32'(bus_cyc_o), 32'd0);

    // Fetch, zero wait states
    if_ce_i = 1'b1; if_addr_i = 32'h4;
    serve("fetch0", 32'h4, 1'b0, 4'hF, 32'h0, 0, 32'h3C01_0001, 1'b0, lat);
    exp_inst = 32'h3C01_0001;
    chk("fetch0_lat", 32'(lat), 32'd1);
    chk("fetch0_inst", if_inst_o, exp_inst);
    chk("fetch0_stall", 32'(if_stall_req_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("fetch0_hold", {31'h0, if_stall_req_o | bus_cyc_o}, 32'd0);
    end
    advance; if_ce_i = 1'b0; #1;
    chk("fetch0_adv_clr", 32'(bus_cyc_o), 32'd0);

    // Priority: load plus fetch, 2 wait states
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h100; mem_sel_i = 4'hF;
    if_ce_i = 1'b1; if_addr_i = 32'h200;
    serve("prio_mem", 32'h100, 1'b0, 4'hF, 32'h0, 2, fmem(32'h100), 1'b0, lat);
    exp_mdata = fmem(32'h100);
    chk("prio_mdata", mem_data_o, exp_mdata);
    chk("prio_mstall", 32'(mem_stall_req_o), 32'd0);
    chk("prio_istall", 32'(if_stall_req_o), 32'd1);
    chk("prio_idle_gap", 32'(bus_cyc_o), 32'd0);
    serve("prio_if", 32'h200, 1'b0, 4'hF, 32'h0, 2, fmem(32'h200), 1'b0, lat);
    exp_inst = fmem(32'h200);
    chk("prio_inst", if_inst_o, exp_inst);
    chk("prio_stalls", {30'h0, if_stall_req_o, mem_stall_req_o}, 32'd0);
    advance;
    chk("prio_adv_both", {30'h0, if_stall_req_o, mem_stall_req_o}, 32'd3);
    mem_ce_i = 1'b0; if_ce_i = 1'b0; tick;

    // Store, 3 wait states
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h300; mem_sel_i = 4'b0011;
    mem_data_i = 32'hDEAD_BEEF;
    serve("store", 32'h300, 1'b1, 4'b0011, 32'hDEAD_BEEF, 3, 32'h1234_5678, 1'b0, lat);
    chk("store_mdata", mem_data_o, exp_mdata);
    chk("store_stall", 32'(mem_stall_req_o), 32'd0);
    advance; mem_ce_i = 1'b0; mem_we_i = 1'b0; tick;

    // Flush mid-fetch: old cycle completes but is discarded, new address fetched after
    if_ce_i = 1'b1; if_addr_i = 32'h40;
    tick;
    chk("flush_cyc", 32'(bus_cyc_o), 32'd1);
    flush_i = 1'b1; if_addr_i = 32'h80; tick; flush_i = 1'b0;
    chk("flush_no_abort", 32'(bus_cyc_o), 32'd1);
    chk("flush_addr_held", bus_addr_o, 32'h40);
    bus_ack_i = 1'b1; bus_data_i = 32'hBAD0_BAD0; tick; bus_ack_i = 1'b0; bus_data_i = '0;
    chk("flush_discard_stall", 32'(if_stall_req_o), 32'd1);
    chk("flush_discard_inst", if_inst_o, exp_inst);
    chk("flush_idle", 32'(bus_cyc_o), 32'd0);
    serve("flush_refetch", 32'h80, 1'b0, 4'hF, 32'h0, 0, fmem(32'h80), 1'b0, lat);
    exp_inst = fmem(32'h80);
    chk("flush_refetch_lat", 32'(lat), 32'd1);
    chk("flush_refetch_inst", if_inst_o, exp_inst);

    // Advance coinciding with ack: the new completion survives
    advance;
    if_addr_i = 32'h84;
    serve("adv_ack", 32'h84, 1'b0, 4'hF, 32'h0, 1, fmem(32'h84), 1'b1, lat);
    exp_inst = fmem(32'h84);
    chk("adv_ack_stall", 32'(if_stall_req_o), 32'd0);
    chk("adv_ack_inst", if_inst_o, exp_inst);
    advance; if_ce_i = 1'b0; tick;

`ifdef ARB_TIMEOUT_EN
    if_ce_i = 1'b1; if_addr_i = 32'h500;
    n = 0;
    while (!bus_cyc_o && n < 40) begin tick; n++; end
    n = 0;
    while (bus_cyc_o && n < 40) begin tick; n++; end
    exp_inst = 32'h0;
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_err", 32'(if_err_o), 32'd1);
    chk("tmo_inst", if_inst_o, exp_inst);
    chk("tmo_stall", 32'(if_stall_req_o), 32'd0);
    advance; if_ce_i = 1'b0; #1;
    chk("tmo_err_clr", 32'(if_err_o), 32'd0);
    tick;
`else
    n = 0;
    chk("no_tmo_err", {30'h0, if_err_o, mem_err_o}, 32'd0);
`endif

    // Randomized transactions
    for (int it = 0; it < 40; it++) begin
      logic mce, mwe, adv;
      logic [31:0] ma, md, ia;
      logic [3:0] ms;
      mce = 1'($urandom_range(0, 1)); mwe = 1'($urandom_range(0, 1));
      ma = $urandom & 32'hFFFF_FFFC; md = $urandom; ms = 4'($urandom_range(1, 15));
      ia = $urandom & 32'hFFFF_FFFC;
      adv = !mce && ($urandom_range(0, 3) == 0);
      mem_ce_i = mce; mem_we_i = mwe; mem_addr_i = ma; mem_data_i = md; mem_sel_i = ms;
      if_ce_i = 1'b1; if_addr_i = ia;
      if (mce) begin
        serve("rnd_mem", ma, mwe, mwe ? ms : ms, md, $urandom_range(0, 3),
              mwe ? 32'hFFFF_0000 : fmem(ma), 1'b0, lat);
        if (!mwe) exp_mdata = fmem(ma);
        chk("rnd_mdata", mem_data_o, exp_mdata);
        chk("rnd_mstall", {30'h0, if_stall_req_o, mem_stall_req_o}, 32'd2);
      end
      serve("rnd_if", ia, 1'b0, 4'hF, 32'h0, $urandom_range(0, 3), fmem(ia), adv, lat);
      exp_inst = fmem(ia);
      chk("rnd_inst", if_inst_o, exp_inst);
      chk("rnd_stalls", {30'h0, if_stall_req_o, mem_stall_req_o}, 32'd0);
      advance;
      mem_ce_i = 1'b0; if_ce_i = 1'b0;
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
